// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : melody_pkg
//  Purpose  : Shared note codes, ROM entry layout, tone half-period table and
//             FSM state type for the melody player.
//  Revision : 1.0  initial release
// ============================================================================
package melody_pkg;

  // Note codes held in the upper field of a ROM entry
  localparam logic [3:0] c_REST = 4'd0;
  localparam logic [3:0] c_L1   = 4'd1;
  localparam logic [3:0] c_L2   = 4'd2;
  localparam logic [3:0] c_L3   = 4'd3;
  localparam logic [3:0] c_L4   = 4'd4;
  localparam logic [3:0] c_L5   = 4'd5;
  localparam logic [3:0] c_L6   = 4'd6;
  localparam logic [3:0] c_L7   = 4'd7;
  localparam logic [3:0] c_M1   = 4'd8;
  localparam logic [3:0] c_M2   = 4'd9;
  localparam logic [3:0] c_M3   = 4'd10;
  localparam logic [3:0] c_M4   = 4'd11;
  localparam logic [3:0] c_M5   = 4'd12;
  localparam logic [3:0] c_M6   = 4'd13;
  localparam logic [3:0] c_M7   = 4'd14;
  localparam logic [3:0] c_END  = 4'd15;

  // ROM entry layout: {note[3:0], beats_minus_one[1:0]}
  localparam int ENTRY_W   = 6;
  localparam int NOTE_MSB  = 5;
  localparam int NOTE_LSB  = 2;
  localparam int BEATS_MSB = 1;
  localparam int BEATS_LSB = 0;

  // Width of the un-shifted half-period values below
  localparam int HP_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Half-period in 50 MHz clock cycles, D = F / (2 * f_note)
  function automatic logic [HP_W-1:0] f_half_period(input logic [3:0] note);
    logic [HP_W-1:0] v;
    case (note)
      c_L1:    v = 17'd95555;
      c_L2:    v = 17'd85132;
      c_L3:    v = 17'd75843;
      c_L4:    v = 17'd71586;
      c_L5:    v = 17'd63776;
      c_L6:    v = 17'd56818;
      c_L7:    v = 17'd50618;
      c_M1:    v = 17'd47774;
      c_M2:    v = 17'd42568;
      c_M3:    v = 17'd37919;
      c_M4:    v = 17'd35791;
      c_M5:    v = 17'd31888;
      c_M6:    v = 17'd28409;
      c_M7:    v = 17'd25310;
      c_REST,
      c_END:   v = '0;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tone_gen
//  Purpose  : Square-wave divider. Output starts low and toggles every
//             i_half_period cycles while enabled; idle/cleared holds low.
//  Revision : 1.0  initial release
// ============================================================================
module tone_gen #(
  parameter int DIV_W = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_half_period,
  input  logic             i_clr,
  output logic             o_wave
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_wave;
  logic [DIV_W-1:0] w_last;

  assign w_last = i_half_period - DIV_W'(1);

  // Divider counter and toggle; anything but an enabled, uncleared cycle restarts low
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (i_clr || !i_en) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (r_cnt == w_last) begin
      r_cnt  <= '0;
      r_wave <= ~r_wave;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
    end
  end

  assign o_wave = r_wave;

endmodule
`default_nettype wire

// File: rtl/melody_player.sv
`default_nettype none
// ============================================================================
//  Module   : melody_player
//  Purpose  : Plays one of SONG_CNT ROM note sequences on a buzzer pin with
//             per-note durations, rests, an inter-note gap, loop/one-shot
//             mode and start/stop/done handshakes.
//  Revision : 1.0  initial release
// ============================================================================
module melody_player
  import melody_pkg::*;
#(
  parameter int BEAT_CYCLES = 12000000,
  parameter int GAP_CYCLES  = 500000,
  parameter int SONG_CNT    = 2,
  parameter int SEQ_DEPTH   = 32,
  parameter int DIV_W       = 17,
  parameter int TONE_SHIFT  = 0,
  localparam int IDX_W  = $clog2(SEQ_DEPTH),
  localparam int SEL_W  = (SONG_CNT > 1) ? $clog2(SONG_CNT) : 1,
  localparam int BEAT_W = $clog2(4 * BEAT_CYCLES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [SEL_W-1:0] i_song_sel,
  input  logic             i_loop,
  output logic             o_beep,
  output logic             o_busy,
  output logic             o_done,
  output logic [IDX_W-1:0] o_note_idx
);

  // Down-counter reload values: PLAY lasts beats*BEAT-GAP cycles, GAP lasts GAP cycles
  localparam logic [BEAT_W-1:0] c_DUR1     = BEAT_W'(1 * BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [BEAT_W-1:0] c_DUR2     = BEAT_W'(2 * BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [BEAT_W-1:0] c_DUR3     = BEAT_W'(3 * BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [BEAT_W-1:0] c_DUR4     = BEAT_W'(4 * BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [BEAT_W-1:0] c_GAP_LAST = BEAT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  c_IDX_LAST = IDX_W'(SEQ_DEPTH - 1);

  // Song ROM. Song 2 is a diagnostic pattern with a rest, reachable only when SONG_CNT > 2.
  function automatic logic [ENTRY_W-1:0] f_song_rom(input int song, input int idx);
    logic [3:0] n;
    logic [1:0] b;
    n = c_END;
    b = 2'd0;
    case (song)
      0: case (idx)
           0, 5, 6, 9, 10, 14:   n = c_M1;
           1, 2, 7, 11, 12, 15:  n = c_M3;
           3, 4, 8, 13, 16, 17:  n = c_M5;
           default:              n = c_END;
         endcase
      1: case (idx)
           0:       begin n = c_M5; b = 2'd1; end
           1:       begin n = c_M3; b = 2'd1; end
           2:       begin n = c_M1; b = 2'd3; end
           default: n = c_END;
         endcase
      2: case (idx)
           0:       n = c_M1;
           1:       begin n = c_REST; b = 2'd1; end
           2:       n = c_M1;
           default: n = c_END;
         endcase
      default: n = c_END;
    endcase
    return {n, b};
  endfunction

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [BEAT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_song;
  logic             r_loop;
  logic             r_rest;
  logic             r_busy;
  logic             r_done;
  logic [DIV_W-1:0] r_hp;

  logic [ENTRY_W-1:0] w_entry;
  logic [3:0]         w_note;
  logic [1:0]         w_beats;
  logic               w_is_end;
  logic [BEAT_W-1:0]  w_dur;
  logic [HP_W-1:0]    w_hp_full;
  logic               w_wave;
  logic               w_tone_en;
  logic               w_tone_clr;

  assign w_entry   = f_song_rom(int'(r_song), int'(r_idx));
  assign w_note    = w_entry[NOTE_MSB:NOTE_LSB];
  assign w_beats   = w_entry[BEATS_MSB:BEATS_LSB];
  // The last slot can never hold a playable note, so a missing END still terminates
  assign w_is_end  = (w_note == c_END) || (r_idx == c_IDX_LAST);
  assign w_hp_full = f_half_period(w_note) >> TONE_SHIFT;

  // Select the PLAY length for the entry's beat count
  always_comb begin
    w_dur = c_DUR1;
    case (w_beats)
      2'd0: w_dur = c_DUR1;
      2'd1: w_dur = c_DUR2;
      2'd2: w_dur = c_DUR3;
      2'd3: w_dur = c_DUR4;
      default: w_dur = c_DUR1;
    endcase
  end

  // Sequencer FSM; stop has priority over everything including a same-cycle start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_song  <= '0;
      r_loop  <= 1'b0;
      r_rest  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hp    <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_stop) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_idx   <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_song  <= (int'(i_song_sel) < SONG_CNT) ? i_song_sel : '0;
              r_loop  <= i_loop;
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (w_is_end) begin
              // An empty song finishes even in loop mode to avoid spinning in LOAD
              if ((r_idx == '0) || !r_loop) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_idx <= '0;
              end
            end else begin
              r_hp    <= DIV_W'(w_hp_full);
              r_rest  <= (w_note == c_REST);
              r_cnt   <= w_dur;
              r_state <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (r_cnt == '0) begin
              r_cnt   <= c_GAP_LAST;
              r_state <= ST_GAP;
            end else begin
              r_cnt <= r_cnt - BEAT_W'(1);
            end
          end
          ST_GAP: begin
            if (r_cnt == '0) begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_LOAD;
            end else begin
              r_cnt <= r_cnt - BEAT_W'(1);
            end
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign w_tone_en  = (r_state == ST_PLAY) && !r_rest;
  assign w_tone_clr = (r_state == ST_LOAD);

  tone_gen #(
    .DIV_W (DIV_W)
  ) u_tone_gen (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (w_tone_en),
    .i_half_period (r_hp),
    .i_clr         (w_tone_clr),
    .o_wave        (w_wave)
  );

  // Wave is qualified by the registered state so the pin is silent outside PLAY
  assign o_beep     = w_wave & (r_state == ST_PLAY);
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_note_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_melody_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_melody_player
//  Purpose  : Self-checking bench for melody_player with a cycle-trace
//             reference model built from the song tables and timing rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_melody_player;

  localparam int BEAT  = 40;
  localparam int GAP   = 4;
  localparam int SHIFT = 12;
  localparam int NSONG = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] sel;
  logic       loop_m;
  logic       beep;
  logic       busy;
  logic       done;
  logic [4:0] idx;

  int n_cmp;
  int n_fail;

  typedef struct packed {
    logic       busy;
    logic       beep;
    logic       done;
    logic [4:0] idx;
    logic       chk_idx;
  } exp_t;

  exp_t exp_q[$];

  // Reference songs: note codes and beat counts
  int song_len  [3]     = '{18, 3, 3};
  int song_note [3][18] = '{'{8,10,10,12,12,8,8,10,12,8,8,10,10,12,8,10,12,12},
                            '{12,10,8,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0},
                            '{8,0,8,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
  int song_beat [3][18] = '{'{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1},
                            '{2,2,4,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0},
                            '{1,2,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
  int tone_tab  [15]    = '{0, 95555, 85132, 75843, 71586, 63776, 56818, 50618,
                            47774, 42568, 37919, 35791, 31888, 28409, 25310};

  melody_player #(
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .SONG_CNT    (NSONG),
    .SEQ_DEPTH   (32),
    .DIV_W       (17),
    .TONE_SHIFT  (SHIFT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_stop     (stop),
    .i_song_sel (sel),
    .i_loop     (loop_m),
    .o_beep     (beep),
    .o_busy     (busy),
    .o_done     (done),
    .o_note_idx (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(bit b, bit bp, bit d, int ix, bit ci);
    exp_t e;
    e.busy = b; e.beep = bp; e.done = d; e.idx = 5'(ix); e.chk_idx = ci;
    return e;
  endfunction

  // Expected per-cycle outputs starting with the cycle after the start edge.
  // passes == 0 builds a one-shot run ending with an idle cycle.
  task automatic build_trace(input int s, input int passes);
    int np, hp, dur;
    exp_q.delete();
    np = (passes == 0) ? 1 : passes;
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < song_len[s]; i++) begin
        hp  = tone_tab[song_note[s][i]] >> SHIFT;
        dur = song_beat[s][i] * BEAT - GAP;
        exp_q.push_back(mk(1, 0, 0, i, 1));
        for (int j = 0; j < dur; j++)
          exp_q.push_back(mk(1, (song_note[s][i] == 0) ? 1'b0 : 1'(((j / hp) % 2)), 0, i, 1));
        for (int g = 0; g < GAP; g++)
          exp_q.push_back(mk(1, 0, 0, i, 1));
      end
      exp_q.push_back(mk(1, 0, 0, song_len[s], 1));
    end
    if (passes == 0) begin
      exp_q.push_back(mk(1, 0, 1, song_len[s], 1));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
    end
  endtask

  task automatic do_start(input int s, input bit lp);
    @(negedge clk);
    sel = 2'(s); loop_m = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0; loop_m = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; stop = 0; sel = 0; loop_m = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({beep, busy, done, idx} !== 8'd0) begin
      n_fail++; $display("FAIL reset_hold: got beep=%b busy=%b done=%b idx=%0d, want all 0", beep, busy, done, idx);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({beep, busy, done, idx} !== 8'd0) begin
      n_fail++; $display("FAIL reset_release: got beep=%b busy=%b done=%b idx=%0d, want all 0", beep, busy, done, idx);
    end
  endtask

  // One-shot song 1, then song 0 selected either directly or via an out-of-range index
  task automatic test_oneshot;
    int done_at, model_len, s, sv;
    exp_t e;
    for (int run = 0; run < 2; run++) begin
      s  = (run == 0) ? 1 : 0;
      sv = (run == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 0 : 3);
      build_trace(s, 0);
      model_len = 2;
      for (int i = 0; i < song_len[s]; i++) model_len += song_beat[s][i] * BEAT + 1;
      do_start(sv, 0);
      done_at = -1;
      for (int k = 0; k < exp_q.size(); k++) begin
        e = exp_q[k];
        n_cmp++;
        if (busy !== e.busy || beep !== e.beep || done !== e.done || (e.chk_idx && idx !== e.idx)) begin
          n_fail++;
          if (n_fail < 20) $display("FAIL oneshot_s%0d cyc %0d: got busy=%b beep=%b done=%b idx=%0d want busy=%b beep=%b done=%b idx=%0d",
                                    s, k + 1, busy, beep, done, idx, e.busy, e.beep, e.done, e.idx);
        end
        if (done === 1'b1 && done_at < 0) done_at = k + 1;
        @(negedge clk);
      end
      n_cmp++;
      if (done_at != model_len) begin
        n_fail++; $display("FAIL oneshot_done_time s%0d: got %0d want %0d", s, done_at, model_len);
      end
    end
  endtask

  // Song 0 looping for three full passes plus a random tail, then stop
  task automatic test_loop_stop;
    int n;
    exp_t e;
    build_trace(0, 4);
    n = 3 * (18 * (BEAT + 1) + 1) + $urandom_range(1, 700);
    do_start(0, 1);
    for (int k = 0; k < n; k++) begin
      e = exp_q[k];
      n_cmp++;
      if (busy !== e.busy || beep !== e.beep || done !== e.done || idx !== e.idx) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL loop cyc %0d: got busy=%b beep=%b done=%b idx=%0d want busy=%b beep=%b done=%b idx=%0d",
                                  k + 1, busy, beep, done, idx, e.busy, e.beep, e.done, e.idx);
      end
      if (k == n - 1) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (busy !== 1'b0 || beep !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL loop_stop cyc %0d: got busy=%b beep=%b done=%b want 0 0 0", k, busy, beep, done);
      end
      @(negedge clk);
    end
  endtask

  // Start re-pulsed with another song mid-play must not disturb song 1
  task automatic test_ignore_start;
    int pk;
    exp_t e;
    build_trace(1, 0);
    pk = $urandom_range(5, 300);
    do_start(1, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      n_cmp++;
      if (busy !== e.busy || beep !== e.beep || done !== e.done || (e.chk_idx && idx !== e.idx)) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL ignore_start cyc %0d: got busy=%b beep=%b done=%b idx=%0d want busy=%b beep=%b done=%b idx=%0d",
                                  k + 1, busy, beep, done, idx, e.busy, e.beep, e.done, e.idx);
      end
      if (k == pk)     begin sel = 2'd0; loop_m = 1'b1; start = 1'b1; end
      if (k == pk + 1) begin start = 1'b0; loop_m = 1'b0; end
      @(negedge clk);
    end
  endtask

  task automatic test_stop_cases;
    int ent, kstop;
    exp_t e;
    // Same-cycle start and stop while idle
    @(negedge clk);
    sel = 2'd1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (busy !== 1'b0 || beep !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL start_stop_idle cyc %0d: got busy=%b beep=%b done=%b want 0 0 0", k, busy, beep, done);
      end
      @(negedge clk);
    end
    // Stop inside a random gap, then a fresh start replays from entry 0
    build_trace(0, 0);
    ent   = $urandom_range(0, 17);
    kstop = ent * (BEAT + 1) + 1 + (BEAT - GAP) + $urandom_range(0, GAP - 1);
    for (int run = 0; run < 2; run++) begin
      do_start(0, 0);
      for (int k = 0; k <= ((run == 0) ? kstop : 120); k++) begin
        e = exp_q[k];
        n_cmp++;
        if (busy !== e.busy || beep !== e.beep || done !== e.done || idx !== e.idx) begin
          n_fail++;
          if (n_fail < 20) $display("FAIL gap_stop run%0d cyc %0d: got busy=%b beep=%b done=%b idx=%0d want busy=%b beep=%b done=%b idx=%0d",
                                    run, k + 1, busy, beep, done, idx, e.busy, e.beep, e.done, e.idx);
        end
        if (k == ((run == 0) ? kstop : 120)) stop = 1'b1;
        @(negedge clk);
      end
      stop = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || beep !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL gap_stop_idle run%0d: got busy=%b beep=%b done=%b want 0 0 0", run, busy, beep, done);
      end
    end
  endtask

  // Song 2 carries a two-beat rest as its second entry
  task automatic test_rest;
    int highs, lows;
    exp_t e;
    build_trace(2, 0);
    highs = 0; lows = 0;
    do_start(2, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      n_cmp++;
      if (busy !== e.busy || beep !== e.beep || done !== e.done || (e.chk_idx && idx !== e.idx)) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rest cyc %0d: got busy=%b beep=%b done=%b idx=%0d want busy=%b beep=%b done=%b idx=%0d",
                                  k + 1, busy, beep, done, idx, e.busy, e.beep, e.done, e.idx);
      end
      if (k >= BEAT + 1 && k < BEAT + 1 + 2 * BEAT + 1) begin
        if (beep !== 1'b0) highs++;
        if (busy !== 1'b1) lows++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (highs != 0 || lows != 0) begin
      n_fail++; $display("FAIL rest_window: got beep_high=%0d busy_low=%0d want 0 0", highs, lows);
    end
  endtask

  // Asynchronous reset in the middle of entry 1's note
  task automatic test_async_reset;
    int kr;
    exp_t e;
    build_trace(1, 0);
    kr = $urandom_range(82, 150);
    do_start(1, 0);
    for (int k = 0; k <= kr; k++) begin
      e = exp_q[k];
      n_cmp++;
      if (busy !== e.busy || beep !== e.beep || done !== e.done || idx !== e.idx) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL arst_pre cyc %0d: got busy=%b beep=%b done=%b idx=%0d want busy=%b beep=%b done=%b idx=%0d",
                                  k + 1, busy, beep, done, idx, e.busy, e.beep, e.done, e.idx);
      end
      if (k < kr) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (beep !== 1'b0 || busy !== 1'b0 || idx !== 5'd0) begin
      n_fail++; $display("FAIL arst_immediate: got beep=%b busy=%b idx=%0d want 0 0 0", beep, busy, idx);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || beep !== 1'b0 || done !== 1'b0 || idx !== 5'd0) begin
        n_fail++; $display("FAIL arst_idle cyc %0d: got busy=%b beep=%b done=%b idx=%0d want 0 0 0 0", k, busy, beep, done, idx);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_oneshot();
    test_loop_stop();
    test_ignore_start();
    test_stop_cases();
    test_rest();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
